// File: rtl/fft_pkg.sv
// Shared FFT types: sample packing constants and butterfly FSM encoding.
// Imported by the butterfly stage and its interface.
package fft_pkg;

  localparam int DW_DEFAULT = 16;

  localparam int RE_MSB = 2*DW_DEFAULT-1;
  localparam int RE_LSB = DW_DEFAULT;
  localparam int IM_MSB = DW_DEFAULT-1;
  localparam int IM_LSB = 0;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_SUM  = 2'd2,
    S_DIFF = 2'd3
  } state_t;

endpackage

// File: rtl/fft_stream_if.sv
// Complex sample stream with valid/ready handshake and frame-last flag.
// Packing is {re, im}, each DW bits two's complement.
interface fft_stream_if #(
  parameter int DW = fft_pkg::DW_DEFAULT
) ();

  logic [2*DW-1:0] data;
  logic            valid;
  logic            ready;
  logic            last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/fft_addsub_sat.sv
// One real component of the butterfly: widened add/sub, then
// either halve (never overflows) or clamp to DW bits.
module fft_addsub_sat #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  input  logic          scale,
  output logic [DW-1:0] result,
  output logic          sat
);

  logic [DW:0] ae;
  logic [DW:0] be;
  logic [DW:0] s;

  always_comb begin
    ae     = {a[DW-1], a};
    be     = {b[DW-1], b};
    s      = sub ? (ae - be) : (ae + be);
    sat    = 1'b0;
    result = s[DW-1:0];
    if (scale) begin
      result = s[DW:1];
    end else if (s[DW] != s[DW-1]) begin
      // Top two bits disagree: value left the DW-bit range.
      sat    = 1'b1;
      result = s[DW] ? {1'b1, {(DW-1){1'b0}}}
                     : {1'b0, {(DW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fft_bfly_r2.sv
// Radix-2 butterfly stage: takes A then W*B, emits A+WB then A-WB
// with optional halving or saturation, and marks the last pair of a frame.
module fft_bfly_r2 #(
  parameter int DW              = fft_pkg::DW_DEFAULT,
  parameter int SCALE           = 1,
  parameter int PAIRS_PER_FRAME = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fft_stream_if.slave   up,
  fft_stream_if.master  dn,
  output logic          o_ovf
);

  import fft_pkg::*;

  localparam int CW =
    (PAIRS_PER_FRAME > 1) ? $clog2(PAIRS_PER_FRAME) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PAIRS_PER_FRAME-1);
  localparam logic          SC      = (SCALE != 0);

  state_t st_q;
  state_t st_d;

  logic [DW-1:0]   a_re_q;
  logic [DW-1:0]   a_im_q;
  logic [DW-1:0]   wb_re_q;
  logic [DW-1:0]   wb_im_q;
  logic [DW-1:0]   b_re;
  logic [DW-1:0]   b_im;
  logic [DW-1:0]   r_re;
  logic [DW-1:0]   r_im;
  logic            sat_re;
  logic            sat_im;
  logic            sub;
  logic [2*DW-1:0] dout_q;
  logic            last_q;
  logic            sat_q;
  logic [CW-1:0]   cnt_q;
  logic            in_xfer;
  logic            out_xfer;

  assign in_xfer  = up.valid & up.ready;
  assign out_xfer = dn.valid & dn.ready;

  // Sum is formed from the live WB word so it is ready next cycle.
  assign b_re = (st_q == S_B) ? up.data[2*DW-1:DW] : wb_re_q;
  assign b_im = (st_q == S_B) ? up.data[DW-1:0]    : wb_im_q;
  assign sub  = (st_q == S_SUM);

  assign dn.data = dout_q;
  assign dn.last = last_q;

  fft_addsub_sat #(.DW(DW)) u_re (
    .a      (a_re_q),
    .b      (b_re),
    .sub    (sub),
    .scale  (SC),
    .result (r_re),
    .sat    (sat_re)
  );

  fft_addsub_sat #(.DW(DW)) u_im (
    .a      (a_im_q),
    .b      (b_im),
    .sub    (sub),
    .scale  (SC),
    .result (r_im),
    .sat    (sat_im)
  );

  always_comb begin
    st_d     = st_q;
    up.ready = 1'b0;
    dn.valid = 1'b0;
    unique case (st_q)
      S_A: begin
        up.ready = ~i_rst;
        if (up.valid) st_d = S_B;
      end
      S_B: begin
        up.ready = ~i_rst;
        if (up.valid) st_d = S_SUM;
      end
      S_SUM: begin
        dn.valid = 1'b1;
        if (dn.ready) st_d = S_DIFF;
      end
      S_DIFF: begin
        dn.valid = 1'b1;
        if (dn.ready) st_d = S_A;
      end
      default: st_d = S_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q    <= S_A;
      a_re_q  <= '0;
      a_im_q  <= '0;
      wb_re_q <= '0;
      wb_im_q <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      o_ovf   <= 1'b0;
    end else begin
      st_q <= st_d;
      if (in_xfer && st_q == S_A) begin
        a_re_q <= up.data[2*DW-1:DW];
        a_im_q <= up.data[DW-1:0];
      end
      if (in_xfer && st_q == S_B) begin
        wb_re_q <= up.data[2*DW-1:DW];
        wb_im_q <= up.data[DW-1:0];
        dout_q  <= {r_re, r_im};
        sat_q   <= sat_re | sat_im;
        last_q  <= 1'b0;
      end
      if (out_xfer) begin
        // Overflow counts only once the clamped word is consumed.
        if (sat_q) o_ovf <= 1'b1;
        if (st_q == S_SUM) begin
          dout_q <= {r_re, r_im};
          sat_q  <= sat_re | sat_im;
          last_q <= (cnt_q == CNT_MAX);
        end else begin
          last_q <= 1'b0;
          cnt_q  <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
      end
    end
  end

endmodule
